exmem_skid_reg: RTL and testbench
=================================

# exmem_skid_reg

Parametrised EX/MEM pipeline stage register with a valid/ready handshake and a two-entry skid buffer, so the memory stage can stall without a combinational ready path back into execute. It sits between the execute stage (ALU result, store data, destination register, memory controls) and the memory stage. It supports synchronous flush for branch and exception squash, and forces memory/writeback controls inactive whenever it holds no valid entry.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store-data (port C) fields
- REG_AW, 4, destination register address width
- SIZE_W, 2, memory access size field width

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-low
- Flush  in  1  synchronous squash of all held entries
- In_Valid  in  1  execute stage presents an entry
- In_Ready  out  1  register can accept; equals NOT skid-entry-valid
- Size_In, Enable_In, rw_In, Load_In, rf_In  in  SIZE_W/1/1/1/1  memory size, memory enable, read/write, load select, register-file write
- RegFile_PortC_In  in  DATA_W  store data
- ALU_In  in  DATA_W  ALU result / address
- Rd_In  in  REG_AW  destination register
- Out_Valid  out  1  head entry valid
- Out_Ready  in  1  memory stage consumes head
- Size_Out, Enable_Out, rw_Out, Load_Out, rf_Out, RegFile_PortC_Out, ALU_Out, Rd_Out  out  as inputs  head entry payload

## Operation
- Storage: head entry (drives outputs) and skid entry, each with a valid bit.
- Accept when In_Valid AND In_Ready; pop when Out_Valid AND Out_Ready.
- States: EMPTY (no valid), ONE (head only), FULL (head + skid).
- EMPTY: accept -> ONE, payload loaded into head.
- ONE: accept+pop -> ONE, head replaced with new payload; accept only -> FULL, payload into skid; pop only -> EMPTY; neither -> hold.
- FULL: In_Ready=0, In_Valid ignored; pop -> ONE, skid moves to head; else hold.
- Flush has priority over all events: next state EMPTY, entry presented that cycle is dropped, a pop that cycle still counts as consumed by downstream.
- Control gating: Enable_Out, rw_Out, Load_Out, rf_Out are 0 whenever Out_Valid=0. Size_Out, RegFile_PortC_Out, ALU_Out, Rd_Out hold their last head value when invalid.
- Payload is never modified; no width conversion.

## Timing
- Reset (CLR=0): state EMPTY, Out_Valid=0, In_Ready=1, all payload outputs 0, all controls 0; applies mid-transfer and discards both entries.
- Latency: entry accepted at edge N appears on outputs after edge N, with Out_Valid=1 from N for one or more cycles.
- Throughput: one entry per cycle while Out_Ready=1.
- In_Ready and Out_Valid are pure functions of registered state; no combinational path from Out_Ready or In_Valid to any output.
- Out_Valid with its payload stays stable until popped or flushed.
- After Flush at edge N: Out_Valid=0 and In_Ready=1 from N.
- Release of CLR is synchronous to CLK in the integrating design.

## Configuration
- EXMEM_STALL_CNT_EN defined: adds output Stall_Cnt (16 bits), which counts cycles with Out_Valid=1 and Out_Ready=0.
  - Saturates at 0xFFFF.
  - Reset to 0 by CLR only; Flush does not clear it.
- Not defined: no Stall_Cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Reset: assert CLR=0 mid-FULL, then release -> Out_Valid=0, In_Ready=1, ALU_Out=0, Rd_Out=0, all controls 0.
- Streaming: Out_Ready=1, entries ALU_In=0x10,0x20,0x30 on consecutive cycles -> same values on ALU_Out one cycle later each, no bubbles, In_Ready always 1.
- Stall/skid: Out_Ready=0, push 0xA then 0xB -> FULL, In_Ready=0, and 0xC held on input is not accepted; then Out_Ready=1 -> 0xA, 0xB, 0xC delivered in order, none lost or duplicated.
- Flush: in FULL with rf=1 entries, pulse Flush together with In_Valid=1 -> next cycle Out_Valid=0, rf_Out=0, Enable_Out=0, In_Ready=1, and the flushed input never appears.
- Control gating: pop the last entry (Load=1, Enable=1, Rd=5) with no new input -> Out_Valid=0, Load_Out=0, Enable_Out=0, Rd_Out stays 5.
- EXMEM_STALL_CNT_EN: hold Out_Valid=1, Out_Ready=0 for 70000 cycles -> Stall_Cnt=0xFFFF; Flush leaves it unchanged; CLR=0 clears it to 0.

Source files
------------

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// Optional EXMEM_STALL_CNT_EN adds a saturating 16-bit downstream-stall cycle counter.
module exmem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int SIZE_W = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [SIZE_W-1:0] Size_In,
    input  logic              Enable_In,
    input  logic              rw_In,
    input  logic              Load_In,
    input  logic              rf_In,
    input  logic [DATA_W-1:0] RegFile_PortC_In,
    input  logic [DATA_W-1:0] ALU_In,
    input  logic [REG_AW-1:0] Rd_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [SIZE_W-1:0] Size_Out,
    output logic              Enable_Out,
    output logic              rw_Out,
    output logic              Load_Out,
    output logic              rf_Out,
    output logic [DATA_W-1:0] RegFile_PortC_Out,
    output logic [DATA_W-1:0] ALU_Out,
    output logic [REG_AW-1:0] Rd_Out
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]       Stall_Cnt
`endif
);

    localparam int PW = SIZE_W + 4 + 2 * DATA_W + REG_AW;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_skid;
    logic [PW-1:0]   w_in;
    logic            w_accept;
    logic            w_pop;
    logic            w_head_ld;
    logic            w_head_from_skid;
    logic            w_skid_ld;

    logic [SIZE_W-1:0] w_size;
    logic              w_en;
    logic              w_rw;
    logic              w_ld;
    logic              w_rf;
    logic [DATA_W-1:0] w_pc;
    logic [DATA_W-1:0] w_alu;
    logic [REG_AW-1:0] w_rd;

    assign w_in = {Size_In, Enable_In, rw_In, Load_In, rf_In, RegFile_PortC_In, ALU_In, Rd_In};
    assign {w_size, w_en, w_rw, w_ld, w_rf, w_pc, w_alu, w_rd} = r_head;

    // Handshake flags depend only on registered state, so no ready path crosses the stage.
    assign Out_Valid = (r_state != S_EMPTY);
    assign In_Ready  = (r_state != S_FULL);
    assign w_accept  = In_Valid && In_Ready;
    assign w_pop     = Out_Valid && Out_Ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_head_ld        = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        if (Flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_head_ld   = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        w_head_ld = 1'b1;
                    end else if (w_accept) begin
                        w_skid_ld   = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_head_ld        = 1'b1;
                        w_head_from_skid = 1'b1;
                        w_state_nxt      = S_ONE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_head_ld) r_head <= w_head_from_skid ? r_skid : w_in;
            if (w_skid_ld) r_skid <= w_in;
        end
    end

    // Memory/writeback controls are forced inactive when no entry is held; data fields keep last head.
    assign Size_Out          = w_size;
    assign Enable_Out        = w_en && Out_Valid;
    assign rw_Out            = w_rw && Out_Valid;
    assign Load_Out          = w_ld && Out_Valid;
    assign rf_Out            = w_rf && Out_Valid;
    assign RegFile_PortC_Out = w_pc;
    assign ALU_Out           = w_alu;
    assign Rd_Out            = w_rd;

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_stall_cnt <= '0;
        end else if (Out_Valid && !Out_Ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign Stall_Cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Directed + randomized bench for exmem_skid_reg against a queue-based reference model.
// Stall-counter checks are compiled in when EXMEM_STALL_CNT_EN is defined.
module tb_exmem_skid_reg;

    typedef struct packed {
        logic [1:0]  size;
        logic        en;
        logic        rw;
        logic        ld;
        logic        rf;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [3:0]  rd;
    } ent_t;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        Flush;
    logic        In_Valid;
    logic        In_Ready;
    logic [1:0]  Size_In;
    logic        Enable_In, rw_In, Load_In, rf_In;
    logic [31:0] RegFile_PortC_In, ALU_In;
    logic [3:0]  Rd_In;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [1:0]  Size_Out;
    logic        Enable_Out, rw_Out, Load_Out, rf_Out;
    logic [31:0] RegFile_PortC_Out, ALU_Out;
    logic [3:0]  Rd_Out;
`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] Stall_Cnt;
`endif

    exmem_skid_reg #(.DATA_W(32), .REG_AW(4), .SIZE_W(2)) dut (
        .CLK(CLK), .CLR(CLR), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Size_In(Size_In), .Enable_In(Enable_In), .rw_In(rw_In), .Load_In(Load_In), .rf_In(rf_In),
        .RegFile_PortC_In(RegFile_PortC_In), .ALU_In(ALU_In), .Rd_In(Rd_In),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Size_Out(Size_Out), .Enable_Out(Enable_Out), .rw_Out(rw_Out), .Load_Out(Load_Out), .rf_Out(rf_Out),
        .RegFile_PortC_Out(RegFile_PortC_Out), .ALU_Out(ALU_Out), .Rd_Out(Rd_Out)
`ifdef EXMEM_STALL_CNT_EN
        , .Stall_Cnt(Stall_Cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: an ordered queue of at most two entries, plus the last head seen.
    ent_t q[$];
    ent_t last_head;
    int   m_stall;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        logic v;
        ent_t h;
        v = (q.size() > 0);
        h = v ? q[0] : last_head;
        chk({tag, ":ov"},   64'(Out_Valid), 64'(v));
        chk({tag, ":ir"},   64'(In_Ready),  64'(q.size() < 2));
        chk({tag, ":en"},   64'(Enable_Out), 64'(v & h.en));
        chk({tag, ":rw"},   64'(rw_Out),     64'(v & h.rw));
        chk({tag, ":ld"},   64'(Load_Out),   64'(v & h.ld));
        chk({tag, ":rf"},   64'(rf_Out),     64'(v & h.rf));
        chk({tag, ":size"}, 64'(Size_Out),   64'(h.size));
        chk({tag, ":pc"},   64'(RegFile_PortC_Out), 64'(h.pc));
        chk({tag, ":alu"},  64'(ALU_Out),    64'(h.alu));
        chk({tag, ":rd"},   64'(Rd_Out),     64'(h.rd));
`ifdef EXMEM_STALL_CNT_EN
        chk({tag, ":scnt"}, 64'(Stall_Cnt),  64'(m_stall));
`endif
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e = ent_t'({$urandom, $urandom, $urandom});
        return e;
    endfunction

    function automatic ent_t mk(input logic [31:0] alu, input logic [3:0] rd,
                                input logic en, input logic ld, input logic rf);
        ent_t e;
        e = rnd_ent();
        e.alu = alu; e.rd = rd; e.en = en; e.ld = ld; e.rf = rf;
        return e;
    endfunction

    // One clock: drive at negedge, model advances on the edge, outputs checked at the next negedge.
    task automatic step(input string tag, input logic iv, input logic ordy, input logic fl, input ent_t e);
        logic acc, pop;
        In_Valid = iv; Out_Ready = ordy; Flush = fl;
        {Size_In, Enable_In, rw_In, Load_In, rf_In, RegFile_PortC_In, ALU_In, Rd_In} = e;
        acc = iv && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        @(posedge CLK);
        if ((q.size() > 0) && !ordy && m_stall < 65535) m_stall++;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() > 0) last_head = q[0];
        @(negedge CLK);
        check(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, ordy, 1'b0, rnd_ent());
    endtask

    task automatic do_reset(input string tag);
        CLR = 1'b0;
        q.delete();
        last_head = '0;
        m_stall = 0;
        #2;
        check({tag, ":in"});
        @(negedge CLK);
        CLR = 1'b1;
        check({tag, ":out"});
    endtask

    initial begin
        ent_t e;
        CLR = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        {Size_In, Enable_In, rw_In, Load_In, rf_In, RegFile_PortC_In, ALU_In, Rd_In} = '0;
        last_head = '0; m_stall = 0;
        @(negedge CLK);
        do_reset("por");

        // Reset while FULL discards both entries
        step("fill0", 1'b1, 1'b0, 1'b0, mk(32'h111, 4'd1, 1'b1, 1'b1, 1'b1));
        step("fill1", 1'b1, 1'b0, 1'b0, mk(32'h222, 4'd2, 1'b1, 1'b1, 1'b1));
        chk("full_ir", 64'(In_Ready), 64'd0);
        do_reset("rst_full");
        chk("rst_alu", 64'(ALU_Out), 64'd0);
        chk("rst_rd", 64'(Rd_Out), 64'd0);

        // Streaming with no bubbles
        step("s10", 1'b1, 1'b1, 1'b0, mk(32'h10, 4'd3, 1'b1, 1'b0, 1'b1));
        chk("s10_alu", 64'(ALU_Out), 64'h10);
        step("s20", 1'b1, 1'b1, 1'b0, mk(32'h20, 4'd3, 1'b1, 1'b0, 1'b1));
        chk("s20_alu", 64'(ALU_Out), 64'h20);
        step("s30", 1'b1, 1'b1, 1'b0, mk(32'h30, 4'd3, 1'b1, 1'b0, 1'b1));
        chk("s30_alu", 64'(ALU_Out), 64'h30);
        chk("s30_ir", 64'(In_Ready), 64'd1);
        idle("s_drain", 1'b1);

        // Stall into skid, C held off while FULL, then ordered drain
        step("skA", 1'b1, 1'b0, 1'b0, mk(32'hA, 4'd4, 1'b0, 1'b0, 1'b1));
        step("skB", 1'b1, 1'b0, 1'b0, mk(32'hB, 4'd4, 1'b0, 1'b0, 1'b1));
        e = mk(32'hC, 4'd4, 1'b0, 1'b0, 1'b1);
        step("skC_hold", 1'b1, 1'b0, 1'b0, e);
        chk("sk_ir0", 64'(In_Ready), 64'd0);
        chk("sk_headA", 64'(ALU_Out), 64'hA);
        step("sk_popA", 1'b1, 1'b1, 1'b0, e);
        chk("sk_headB", 64'(ALU_Out), 64'hB);
        step("sk_popB", 1'b1, 1'b1, 1'b0, e);
        chk("sk_headC", 64'(ALU_Out), 64'hC);
        idle("sk_popC", 1'b1);
        chk("sk_empty", 64'(Out_Valid), 64'd0);

        // Flush from FULL with an entry presented the same cycle
        step("flA", 1'b1, 1'b0, 1'b0, mk(32'h51, 4'd6, 1'b1, 1'b0, 1'b1));
        step("flB", 1'b1, 1'b0, 1'b0, mk(32'h52, 4'd6, 1'b1, 1'b0, 1'b1));
        step("fl", 1'b1, 1'b0, 1'b1, mk(32'hDEAD, 4'd7, 1'b1, 1'b1, 1'b1));
        chk("fl_ov", 64'(Out_Valid), 64'd0);
        chk("fl_rf", 64'(rf_Out), 64'd0);
        chk("fl_ir", 64'(In_Ready), 64'd1);
        idle("fl_after", 1'b1);
        chk("fl_nodead", 64'(ALU_Out == 32'hDEAD), 64'd0);

        // Control gating after the last entry leaves
        step("gt_push", 1'b1, 1'b1, 1'b0, mk(32'h77, 4'd5, 1'b1, 1'b1, 1'b0));
        idle("gt_pop", 1'b1);
        chk("gt_ov", 64'(Out_Valid), 64'd0);
        chk("gt_ld", 64'(Load_Out), 64'd0);
        chk("gt_en", 64'(Enable_Out), 64'd0);
        chk("gt_rd", 64'(Rd_Out), 64'd5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), rnd_ent());
        end

`ifdef EXMEM_STALL_CNT_EN
        // Saturating stall counter, untouched by Flush, cleared by CLR
        do_reset("sc_rst");
        step("sc_push", 1'b1, 1'b0, 1'b0, mk(32'h99, 4'd9, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 70000; i++) idle("sc_hold", 1'b0);
        chk("sc_sat", 64'(Stall_Cnt), 64'hFFFF);
        step("sc_flush", 1'b0, 1'b0, 1'b1, rnd_ent());
        chk("sc_flush", 64'(Stall_Cnt), 64'hFFFF);
        do_reset("sc_clr");
        chk("sc_clr0", 64'(Stall_Cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
